// File: rtl/sc_nestctrl_if.sv
// rtl/sc_nestctrl_if.sv - game-step controller bus: control inputs in, strobes and status out
interface sc_nestctrl_if #(
  parameter int SCORE_WIDTH = 4
);
  logic                   SC_NESTCTRL_start_InLow;
  logic                   SC_NESTCTRL_tick_InHigh;
  logic                   SC_NESTCTRL_nest_InLow;
  logic                   SC_NESTCTRL_left_InLow;
  logic                   SC_NESTCTRL_right_InLow;
  logic                   SC_NESTCTRL_clear_OutHigh;
  logic                   SC_NESTCTRL_shift_OutHigh;
  logic [SCORE_WIDTH-1:0] SC_NESTCTRL_score_OutBUS;
  logic                   SC_NESTCTRL_side_OutHigh;
  logic                   SC_NESTCTRL_playing_OutHigh;
  logic                   SC_NESTCTRL_win_OutLow;
  logic                   SC_NESTCTRL_lose_OutLow;

  modport master (
    output SC_NESTCTRL_start_InLow, SC_NESTCTRL_tick_InHigh, SC_NESTCTRL_nest_InLow,
           SC_NESTCTRL_left_InLow, SC_NESTCTRL_right_InLow,
    input  SC_NESTCTRL_clear_OutHigh, SC_NESTCTRL_shift_OutHigh, SC_NESTCTRL_score_OutBUS,
           SC_NESTCTRL_side_OutHigh, SC_NESTCTRL_playing_OutHigh, SC_NESTCTRL_win_OutLow,
           SC_NESTCTRL_lose_OutLow
  );

  modport slave (
    input  SC_NESTCTRL_start_InLow, SC_NESTCTRL_tick_InHigh, SC_NESTCTRL_nest_InLow,
           SC_NESTCTRL_left_InLow, SC_NESTCTRL_right_InLow,
    output SC_NESTCTRL_clear_OutHigh, SC_NESTCTRL_shift_OutHigh, SC_NESTCTRL_score_OutBUS,
           SC_NESTCTRL_side_OutHigh, SC_NESTCTRL_playing_OutHigh, SC_NESTCTRL_win_OutLow,
           SC_NESTCTRL_lose_OutLow
  );
endinterface

// File: rtl/sc_nestctrl.sv
// rtl/sc_nestctrl.sv - nest game sequencer: clear/shift strobes, hit scoring, win/lose status
// Optional loss on hitless ticks is enabled by defining SC_NESTCTRL_TIMEOUT_EN.
module sc_nestctrl #(
  parameter int SCORE_WIDTH   = 4,
  parameter int WIN_SCORE     = 9,
  parameter int TIMEOUT_TICKS = 16
) (
  input logic          SC_NESTCTRL_CLOCK_50,
  input logic          SC_NESTCTRL_RESET_InLow,
  sc_nestctrl_if.slave bus
);

  localparam logic [SCORE_WIDTH-1:0] WIN_VAL = SCORE_WIDTH'(WIN_SCORE);

  if (WIN_SCORE < 1 || WIN_SCORE > (2**SCORE_WIDTH) - 1 || TIMEOUT_TICKS < 1) begin : g_param_check
    $error("sc_nestctrl: WIN_SCORE or TIMEOUT_TICKS out of range");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_PLAY, S_SHIFT, S_SETTLE, S_CHECK, S_SCORE, S_WIN, S_LOSE
  } state_t;

  state_t                 r_state;
  logic                   r_start_prev;
  logic                   r_clear;
  logic                   r_shift;
  logic [SCORE_WIDTH-1:0] r_score;
  logic                   r_side;
  logic                   r_playing;
  logic                   r_win_n;
  logic                   r_lose_n;

  logic                   w_start_edge;
  logic                   w_hit;
  logic                   w_right_only;
  logic [SCORE_WIDTH-1:0] w_score_inc;

  assign w_start_edge = r_start_prev & ~bus.SC_NESTCTRL_start_InLow;
  assign w_hit        = ~bus.SC_NESTCTRL_nest_InLow;
  assign w_right_only = ~bus.SC_NESTCTRL_right_InLow & bus.SC_NESTCTRL_left_InLow;
  assign w_score_inc  = r_score + 1'b1;

`ifdef SC_NESTCTRL_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_timeout;
  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_TICKS));
`endif

  always_ff @(posedge SC_NESTCTRL_CLOCK_50 or negedge SC_NESTCTRL_RESET_InLow) begin
    if (!SC_NESTCTRL_RESET_InLow) begin
      r_state      <= S_IDLE;
      r_start_prev <= 1'b1;
      r_clear      <= 1'b0;
      r_shift      <= 1'b0;
      r_score      <= '0;
      r_side       <= 1'b0;
      r_playing    <= 1'b0;
      r_win_n      <= 1'b1;
      r_lose_n     <= 1'b1;
`ifdef SC_NESTCTRL_TIMEOUT_EN
      r_to_cnt     <= '0;
`endif
    end else begin
      r_start_prev <= bus.SC_NESTCTRL_start_InLow;
      r_clear      <= 1'b0;
      r_shift      <= 1'b0;
      case (r_state)
        S_IDLE, S_WIN, S_LOSE: begin
          // Outputs are set on entry so the clear strobe and zeroed score show during CLEAR.
          if (w_start_edge) begin
            r_state   <= S_CLEAR;
            r_clear   <= 1'b1;
            r_score   <= '0;
            r_side    <= 1'b0;
            r_playing <= 1'b1;
            r_win_n   <= 1'b1;
            r_lose_n  <= 1'b1;
`ifdef SC_NESTCTRL_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
          end
        end
        S_CLEAR: r_state <= S_PLAY;
        S_PLAY: begin
          if (bus.SC_NESTCTRL_tick_InHigh) begin
            r_state <= S_SHIFT;
            r_shift <= 1'b1;
`ifdef SC_NESTCTRL_TIMEOUT_EN
            r_to_cnt <= r_to_cnt + 1'b1;
`endif
          end
        end
        S_SHIFT:  r_state <= S_SETTLE;
        S_SETTLE: r_state <= S_CHECK;
        S_CHECK: begin
          if (w_hit) begin
            r_state <= S_SCORE;
            r_score <= w_score_inc;
            r_side  <= w_right_only;
            r_clear <= 1'b1;
`ifdef SC_NESTCTRL_TIMEOUT_EN
          end else if (w_timeout) begin
            r_state   <= S_LOSE;
            r_lose_n  <= 1'b0;
            r_playing <= 1'b0;
`endif
          end else begin
            r_state <= S_PLAY;
          end
        end
        S_SCORE: begin
`ifdef SC_NESTCTRL_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
          if (r_score == WIN_VAL) begin
            r_state   <= S_WIN;
            r_win_n   <= 1'b0;
            r_playing <= 1'b0;
          end else begin
            r_state <= S_PLAY;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.SC_NESTCTRL_clear_OutHigh   = r_clear;
  assign bus.SC_NESTCTRL_shift_OutHigh   = r_shift;
  assign bus.SC_NESTCTRL_score_OutBUS    = r_score;
  assign bus.SC_NESTCTRL_side_OutHigh    = r_side;
  assign bus.SC_NESTCTRL_playing_OutHigh = r_playing;
  assign bus.SC_NESTCTRL_win_OutLow      = r_win_n;
  assign bus.SC_NESTCTRL_lose_OutLow     = r_lose_n;

endmodule

// File: tb/tb_sc_nestctrl.sv
// tb/tb_sc_nestctrl.sv - bench for sc_nestctrl: timeline model plus directed literal checks
module tb_sc_nestctrl;

  localparam int SW  = 4;
  localparam int WIN = 9;
`ifdef SC_NESTCTRL_TIMEOUT_EN
  localparam int TT = 3;
`else
  localparam int TT = 16;
`endif
  localparam int BIG = 32'h3fff_ffff;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sc_nestctrl_if #(.SCORE_WIDTH(SW)) u_if ();

  sc_nestctrl #(.SCORE_WIDTH(SW), .WIN_SCORE(WIN), .TIMEOUT_TICKS(TT)) u_dut (
    .SC_NESTCTRL_CLOCK_50    (clk),
    .SC_NESTCTRL_RESET_InLow (rst_n),
    .bus                     (u_if.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Timeline model: each accepted event schedules absolute cycle numbers for its effects.
  int cyc = 0;
  int m_shift_cyc, m_clear_cyc, m_check_cyc, m_accept_from;
  int m_score, m_side, m_playing, m_win_n, m_lose_n, m_to;
  bit m_in_game, m_prev_start, m_win_pend;
  int c;
  bit do_win;

  task automatic m_reset();
    m_shift_cyc = -1; m_clear_cyc = -1; m_check_cyc = -1; m_accept_from = BIG;
    m_score = 0; m_side = 0; m_playing = 0; m_win_n = 1; m_lose_n = 1; m_to = 0;
    m_in_game = 0; m_prev_start = 1; m_win_pend = 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        c = cyc;
        do_win = m_win_pend;
        m_win_pend = 0;
        if (m_in_game && u_if.SC_NESTCTRL_tick_InHigh && c >= m_accept_from) begin
          m_shift_cyc   = c + 1;
          m_check_cyc   = c + 3;
          m_accept_from = BIG;
          m_to++;
        end
        if (c == m_check_cyc) begin
          m_check_cyc = -1;
          if (!u_if.SC_NESTCTRL_nest_InLow) begin
            m_score++;
            m_side = (!u_if.SC_NESTCTRL_right_InLow && u_if.SC_NESTCTRL_left_InLow) ? 1 : 0;
            m_clear_cyc = c + 1;
            m_to = 0;
            if (m_score == WIN) m_win_pend = 1;
            else m_accept_from = c + 2;
          end else begin
`ifdef SC_NESTCTRL_TIMEOUT_EN
            if (m_to == TT) begin
              m_lose_n = 0; m_playing = 0; m_in_game = 0;
            end else m_accept_from = c + 1;
`else
            m_accept_from = c + 1;
`endif
          end
        end
        if (m_prev_start && !u_if.SC_NESTCTRL_start_InLow && !m_in_game) begin
          m_in_game = 1; m_clear_cyc = c + 1; m_accept_from = c + 2; m_check_cyc = -1;
          m_score = 0; m_side = 0; m_win_n = 1; m_lose_n = 1; m_playing = 1; m_to = 0;
        end
        m_prev_start = u_if.SC_NESTCTRL_start_InLow;
        if (do_win) begin
          m_win_n = 0; m_playing = 0; m_in_game = 0;
        end
        cyc = c + 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("m_shift",   int'(u_if.SC_NESTCTRL_shift_OutHigh),   (cyc == m_shift_cyc) ? 1 : 0);
        chk("m_clear",   int'(u_if.SC_NESTCTRL_clear_OutHigh),   (cyc == m_clear_cyc) ? 1 : 0);
        chk("m_score",   int'(u_if.SC_NESTCTRL_score_OutBUS),    m_score);
        chk("m_side",    int'(u_if.SC_NESTCTRL_side_OutHigh),    m_side);
        chk("m_playing", int'(u_if.SC_NESTCTRL_playing_OutHigh), m_playing);
        chk("m_win",     int'(u_if.SC_NESTCTRL_win_OutLow),      m_win_n);
        chk("m_lose",    int'(u_if.SC_NESTCTRL_lose_OutLow),     m_lose_n);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_clear"},   int'(u_if.SC_NESTCTRL_clear_OutHigh),   0);
    chk({tag, "_shift"},   int'(u_if.SC_NESTCTRL_shift_OutHigh),   0);
    chk({tag, "_score"},   int'(u_if.SC_NESTCTRL_score_OutBUS),    0);
    chk({tag, "_side"},    int'(u_if.SC_NESTCTRL_side_OutHigh),    0);
    chk({tag, "_playing"}, int'(u_if.SC_NESTCTRL_playing_OutHigh), 0);
    chk({tag, "_win"},     int'(u_if.SC_NESTCTRL_win_OutLow),      1);
    chk({tag, "_lose"},    int'(u_if.SC_NESTCTRL_lose_OutLow),     1);
  endtask

  int cnt;

  initial begin
    u_if.SC_NESTCTRL_start_InLow = 1'b1;
    u_if.SC_NESTCTRL_tick_InHigh = 1'b0;
    u_if.SC_NESTCTRL_nest_InLow  = 1'b1;
    u_if.SC_NESTCTRL_left_InLow  = 1'b1;
    u_if.SC_NESTCTRL_right_InLow = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    chk_reset_outs("reset");
    rst_n = 1'b1;
    step();

    // Ticks in IDLE are dropped.
    u_if.SC_NESTCTRL_tick_InHigh = 1'b1;
    repeat (4) step();
    u_if.SC_NESTCTRL_tick_InHigh = 1'b0;
    step();
    chk("idle_tick_playing", int'(u_if.SC_NESTCTRL_playing_OutHigh), 0);

    // Start edge, then one hitless tick.
    u_if.SC_NESTCTRL_start_InLow = 1'b0;
    step();
    u_if.SC_NESTCTRL_start_InLow = 1'b1;
    chk("start_clear", int'(u_if.SC_NESTCTRL_clear_OutHigh), 1);
    step();
    u_if.SC_NESTCTRL_tick_InHigh = 1'b1;
    step();
    u_if.SC_NESTCTRL_tick_InHigh = 1'b0;
    chk("tick_shift", int'(u_if.SC_NESTCTRL_shift_OutHigh), 1);
    repeat (4) step();
    chk("miss_score", int'(u_if.SC_NESTCTRL_score_OutBUS), 0);
    chk("miss_playing", int'(u_if.SC_NESTCTRL_playing_OutHigh), 1);

    // Right-only hit: score 1, side 1, clear at tick+4.
    u_if.SC_NESTCTRL_nest_InLow  = 1'b0;
    u_if.SC_NESTCTRL_right_InLow = 1'b0;
    u_if.SC_NESTCTRL_tick_InHigh = 1'b1;
    step();
    u_if.SC_NESTCTRL_tick_InHigh = 1'b0;
    repeat (3) step();
    chk("hit_clear", int'(u_if.SC_NESTCTRL_clear_OutHigh), 1);
    chk("hit_score", int'(u_if.SC_NESTCTRL_score_OutBUS), 1);
    chk("hit_side",  int'(u_if.SC_NESTCTRL_side_OutHigh), 1);
    step();
    u_if.SC_NESTCTRL_nest_InLow  = 1'b1;
    u_if.SC_NESTCTRL_right_InLow = 1'b1;

    // Asynchronous reset while in SHIFT.
    u_if.SC_NESTCTRL_tick_InHigh = 1'b1;
    step();
    u_if.SC_NESTCTRL_tick_InHigh = 1'b0;
    chk("pre_reset_shift", int'(u_if.SC_NESTCTRL_shift_OutHigh), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs("async_reset");
    step();
    step();
    rst_n = 1'b1;
    u_if.SC_NESTCTRL_tick_InHigh = 1'b1;
    repeat (3) step();
    u_if.SC_NESTCTRL_tick_InHigh = 1'b0;
    step();
    chk("post_reset_playing", int'(u_if.SC_NESTCTRL_playing_OutHigh), 0);

    // Ticks every cycle, no hits: one shift per 4 cycles.
    u_if.SC_NESTCTRL_tick_InHigh = 1'b1;
    u_if.SC_NESTCTRL_start_InLow = 1'b0;
    step();
    u_if.SC_NESTCTRL_start_InLow = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      cnt += int'(u_if.SC_NESTCTRL_shift_OutHigh);
    end
`ifdef SC_NESTCTRL_TIMEOUT_EN
    chk("miss_stream_shifts", cnt, 3);
    chk("miss_stream_lose", int'(u_if.SC_NESTCTRL_lose_OutLow), 0);
`else
    chk("miss_stream_shifts", cnt, 10);
`endif
    u_if.SC_NESTCTRL_tick_InHigh = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Ticks every cycle, all hits (both sides low): 9 shifts, one per 5 cycles, then WIN.
    u_if.SC_NESTCTRL_nest_InLow  = 1'b0;
    u_if.SC_NESTCTRL_left_InLow  = 1'b0;
    u_if.SC_NESTCTRL_right_InLow = 1'b0;
    u_if.SC_NESTCTRL_tick_InHigh = 1'b1;
    u_if.SC_NESTCTRL_start_InLow = 1'b0;
    step();
    u_if.SC_NESTCTRL_start_InLow = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      cnt += int'(u_if.SC_NESTCTRL_shift_OutHigh);
    end
    chk("hit_stream_shifts", cnt, 9);
    chk("win_score",   int'(u_if.SC_NESTCTRL_score_OutBUS), 9);
    chk("win_low",     int'(u_if.SC_NESTCTRL_win_OutLow), 0);
    chk("win_playing", int'(u_if.SC_NESTCTRL_playing_OutHigh), 0);
    chk("win_side",    int'(u_if.SC_NESTCTRL_side_OutHigh), 0);
    step();
    repeat (5) step();
    u_if.SC_NESTCTRL_tick_InHigh = 1'b0;
    u_if.SC_NESTCTRL_nest_InLow  = 1'b1;
    u_if.SC_NESTCTRL_left_InLow  = 1'b1;
    u_if.SC_NESTCTRL_right_InLow = 1'b1;

    // Restart from WIN.
    u_if.SC_NESTCTRL_start_InLow = 1'b0;
    step();
    u_if.SC_NESTCTRL_start_InLow = 1'b1;
    chk("restart_clear",   int'(u_if.SC_NESTCTRL_clear_OutHigh), 1);
    chk("restart_score",   int'(u_if.SC_NESTCTRL_score_OutBUS), 0);
    chk("restart_win",     int'(u_if.SC_NESTCTRL_win_OutLow), 1);
    chk("restart_playing", int'(u_if.SC_NESTCTRL_playing_OutHigh), 1);
    step();

`ifdef SC_NESTCTRL_TIMEOUT_EN
    // Two misses, then a hit on the third tick scores instead of losing.
    for (int i = 0; i < 3; i++) begin
      if (i == 2) u_if.SC_NESTCTRL_nest_InLow = 1'b0;
      u_if.SC_NESTCTRL_tick_InHigh = 1'b1;
      step();
      u_if.SC_NESTCTRL_tick_InHigh = 1'b0;
      repeat (3) step();
    end
    chk("to_hit_score", int'(u_if.SC_NESTCTRL_score_OutBUS), 1);
    chk("to_hit_lose",  int'(u_if.SC_NESTCTRL_lose_OutLow), 1);
    u_if.SC_NESTCTRL_nest_InLow = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      u_if.SC_NESTCTRL_tick_InHigh = 1'b1;
      step();
      u_if.SC_NESTCTRL_tick_InHigh = 1'b0;
      repeat (3) step();
    end
    chk("to_lose",         int'(u_if.SC_NESTCTRL_lose_OutLow), 0);
    chk("to_lose_playing", int'(u_if.SC_NESTCTRL_playing_OutHigh), 0);
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
